seq_match_logger: RTL and testbench

- Downstream consumer of the Moore sequence-detector match output `z`.
- Detects each rising edge of the detector's match flag and records when it happened:
  - a free-running cycle timestamp goes into a small show-ahead FIFO;
  - a saturating total-match count is kept alongside.
- A host/CPU-side reader drains the timestamps through a valid/ready handshake.
- Sits between the detector and the status/register block.

---
 rtl/seq_match_logger.sv | 98 +++++++++
 tb/tb_seq_match_logger.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_match_logger.sv
// seq_match_logger: logs a timestamp for each rising edge of z_in into a show-ahead FIFO and keeps a saturating match count.
// Optional `SEQ_MATCH_LOGGER_IRQ_EN adds irq_thresh/irq.
module seq_match_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       z_in,
    input  logic                       clear,
    output logic [TS_W-1:0]            ts_data,
    output logic                       ts_valid,
    input  logic                       ts_ready,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(DEPTH):0]     fifo_level,
`ifdef SEQ_MATCH_LOGGER_IRQ_EN
    input  logic [$clog2(DEPTH):0]     irq_thresh,
    output logic                       irq,
`endif
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [TS_W-1:0]  ts_q, ts_d, last_q, last_d;
    logic             z_prev_q;
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             match, pop, full, push;

    always_comb begin
        match   = z_in & ~z_prev_q;
        pop     = ts_valid & ts_ready;
        full    = level_q == LW'(DEPTH);
        push    = match & ~clear & (~full | pop);
        ts_d    = ts_q + 1'b1;
        wptr_d  = clear ? '0 : wptr_q + AW'(push);
        rptr_d  = clear ? '0 : rptr_q + AW'(pop);
        level_d = clear ? '0 : level_q + LW'(push) - LW'(pop);
        cnt_d   = clear ? '0 : cnt_q + CNT_W'(match & ~&cnt_q);
        ovf_d   = ~clear & (ovf_q | (match & full & ~pop));
        last_d  = pop ? mem_q[rptr_q] : last_q;
    end

    // last_q keeps ts_data stable at the most recently consumed entry once empty
    assign ts_valid    = level_q != '0;
    assign ts_data     = ts_valid ? mem_q[rptr_q] : last_q;
    assign fifo_level  = level_q;
    assign match_count = cnt_q;
    assign overflow    = ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q     <= '0;
            last_q   <= '0;
            z_prev_q <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            last_q   <= last_d;
            z_prev_q <= z_in;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wptr_q] <= ts_q;
    end

`ifdef SEQ_MATCH_LOGGER_IRQ_EN
    logic [LW-1:0] thr;
    logic          irq_q, irq_d;

    always_comb begin
        thr   = (irq_thresh == '0) ? LW'(1) : irq_thresh;
        irq_d = (level_q >= thr) | ovf_q;
    end

    assign irq = irq_q;

    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end
`endif
endmodule

// File: tb/tb_seq_match_logger.sv
// tb_seq_match_logger: directed stimulus with a reference queue model checked every cycle.
module tb_seq_match_logger;
    localparam int TS_W  = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset, z_in, clear, ts_ready;
    logic [TS_W-1:0] ts_data;
    logic            ts_valid, overflow;
    logic [CNT_W-1:0] match_count;
    logic [LW-1:0]   fifo_level;
`ifdef SEQ_MATCH_LOGGER_IRQ_EN
    logic [LW-1:0]   irq_thresh = LW'(2);
    logic            irq;
`endif

    int checks = 0;
    int errors = 0;

    logic [TS_W-1:0] q[$];
    logic [TS_W-1:0] mts;
    int              cnt_m;
    logic            ovf_m, zp, irq_e;

    seq_match_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .z_in(z_in),
        .clear(clear),
        .ts_data(ts_data),
        .ts_valid(ts_valid),
        .ts_ready(ts_ready),
        .match_count(match_count),
        .fifo_level(fifo_level),
`ifdef SEQ_MATCH_LOGGER_IRQ_EN
        .irq_thresh(irq_thresh),
        .irq(irq),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model from pre-edge state, compare after the edge
    task automatic cyc(input logic r, input logic z, input logic rdy, input logic clr);
        logic [TS_W-1:0] h;
        int thr;
        reset = r; z_in = z; ts_ready = rdy; clear = clr;
        if (r) begin
            q.delete(); cnt_m = 0; ovf_m = 0; zp = 0; mts = '0; irq_e = 0;
        end else begin
            thr   = 2;
            irq_e = (q.size() >= thr) || ovf_m;
            if (rdy && q.size() > 0 && !clr) begin
                h = q.pop_front();
                chk("pop_data", 32'(ts_data), 32'(h));
            end
            if (clr) begin
                q.delete(); cnt_m = 0; ovf_m = 0;
            end else if (z && !zp) begin
                if (cnt_m != (1 << CNT_W) - 1) cnt_m++;
                if (q.size() < DEPTH) q.push_back(mts);
                else ovf_m = 1;
            end
            zp = z;
            mts++;
        end
        @(posedge clk);
        #1;
        chk("ts_valid", 32'(ts_valid), 32'(q.size() != 0));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("match_count", 32'(match_count), 32'(cnt_m));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (q.size() > 0) chk("head_data", 32'(ts_data), 32'(q[0]));
`ifdef SEQ_MATCH_LOGGER_IRQ_EN
        chk("irq", 32'(irq), 32'(irq_e));
`endif
    endtask

    task automatic wait_ts(input logic [TS_W-1:0] t);
        for (int g = 0; g < 70000 && mts != t; g++) cyc(0, 0, 0, 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
    endtask

    initial begin
        reset = 1; z_in = 0; clear = 0; ts_ready = 0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("reset_ts_data", 32'(ts_data), 32'd0);
        // single pulse at timestamp 5
        wait_ts(5);
        cyc(0, 1, 0, 0);
        chk("first_entry", 32'(ts_data), 32'd5);
        cyc(0, 0, 0, 0);
        drain(1);
        cyc(0, 0, 0, 1);
        // z_in held high for 4 cycles is one match
        wait_ts(10);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        chk("held_count", 32'(match_count), 32'd1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        // overflow with five matches and no reader
        for (int i = 0; i < 5; i++) begin
            wait_ts(TS_W'(20 + 4 * i));
            cyc(0, 1, 0, 0);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        cyc(0, 0, 0, 0);
        drain(5);
        // full FIFO with simultaneous pop and match
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0);
        end
        cyc(0, 1, 1, 0);
        chk("full_pop_level", 32'(fifo_level), 32'(DEPTH));
        cyc(0, 0, 0, 0);
        drain(5);
        // empty with simultaneous match and ready
        cyc(0, 1, 1, 0);
        cyc(0, 0, 1, 0);
        // saturation
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0);
        end
        chk("saturate", 32'(match_count), 32'd255);
        // clear together with a match, then the held level is not re-counted
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 0);
        chk("clear_count", 32'(match_count), 32'd0);
        cyc(0, 0, 0, 0);
        // reset mid-operation abandons stored entries
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        cyc(1, 1, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        drain(2);
        // timestamp wrap
        cyc(0, 0, 0, 1);
        wait_ts(16'hFFFE);
        wait_ts(16'h0001);
        cyc(0, 1, 0, 0);
        chk("wrap_entry", 32'(ts_data), 32'h0001);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
